md6_bram_arbiter: RTL and testbench

- Shares the MD6 engine's single 32-bit BRAM initiator port between two requesters.
  - req0: PLB-side DMA loader, which moves message/key blocks between PLB and BRAM.
  - req1: MD6 compression-core control, which reads input words and writes the chaining result.
- Arbitration is round-robin, with an optional lock so a requester can run an uninterrupted burst.
- BRAM-side outputs are registered. Read data returns to the issuing requester with fixed latency.
- Sits between the requesters and the top-level bramInitiatorWires_* pins; the word address is shifted to a byte address at top level.

---
 rtl/md6_bram_pkg.sv | 21 ++
 rtl/md6_rd_tag_pipe.sv | 26 ++
 rtl/md6_bram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_md6_bram_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md6_bram_pkg.sv
// Shared types for the MD6 BRAM arbiter: lock FSM states, requester id and
// the read-return tag carried alongside each BRAM read.
package md6_bram_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arbState_t;

  typedef logic reqId_t;

  typedef struct packed {
    logic   valid;
    reqId_t id;
  } rdTag_t;

endpackage

// File: rtl/md6_rd_tag_pipe.sv
// Shift register of read tags that follows each read through the BRAM so the
// registered read data can be steered back to the requester that issued it.
module md6_rd_tag_pipe
  import md6_bram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   CLK,
  input  logic   clear,
  input  rdTag_t tagIn,
  output rdTag_t tagOut
);

  rdTag_t [DEPTH-1:0] stages;

  always_ff @(posedge CLK) begin
    if (clear) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], tagIn};
    end
  end

  assign tagOut = stages[DEPTH-1];

endmodule

// File: rtl/md6_bram_arbiter.sv
// Round-robin arbiter with optional burst lock sharing one BRAM port between
// the PLB DMA loader (req0) and the MD6 compression core (req1).
module md6_bram_arbiter
  import md6_bram_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = 1,
  parameter int LOCK_TMO = 64
) (
  input  logic                CLK,
  input  logic                RST,

  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_write,
  input  logic                req0_lock,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_be,

  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_write,
  input  logic                req1_lock,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_be,

  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_data,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_data,

  output logic                lock_err,

  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_wen,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_dout,
  input  logic [DATA_W-1:0]   bram_din
);

  localparam int BE_W = DATA_W / 8;

  arbState_t        state, stateNext;
  reqId_t           prefer;
  logic [7:0]       tmoCnt, tmoCntNext;
  logic             lockErrNext;
  logic             ownerValid;

  logic             grant0, grant1, accept;
  reqId_t           grantId;
  logic             grantWrite, grantLock;
  logic [ADDR_W-1:0] grantAddr;
  logic [DATA_W-1:0] grantWdata;
  logic [BE_W-1:0]  grantBe;

  rdTag_t           tagIn, tagOut;

  // Owner-only grant while locked; otherwise the preferred side wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      OWN0:    grant0 = req0_valid;
      OWN1:    grant1 = req1_valid;
      default: begin
        grant0 = req0_valid && (!req1_valid || prefer == 1'b0);
        grant1 = req1_valid && (!req0_valid || prefer == 1'b1);
      end
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign grantId    = reqId_t'(grant1);
  assign grantWrite = grant1 ? req1_write : req0_write;
  assign grantLock  = grant1 ? req1_lock  : req0_lock;
  assign grantAddr  = grant1 ? req1_addr  : req0_addr;
  assign grantWdata = grant1 ? req1_wdata : req0_wdata;
  assign grantBe    = grant1 ? req1_be    : req0_be;

  always_comb begin
    stateNext   = state;
    tmoCntNext  = tmoCnt;
    lockErrNext = 1'b0;
    ownerValid  = (state == OWN1) ? req1_valid : req0_valid;
    case (state)
      IDLE: begin
        if (accept && grantLock) begin
          stateNext = grant1 ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        if (accept) begin
          tmoCntNext = 8'd0;
          if (!grantLock) begin
            stateNext = IDLE;
          end
        end else if (!ownerValid) begin
          // The idle cycle that brings the count to LOCK_TMO forces release.
          if (tmoCnt == 8'(LOCK_TMO - 1)) begin
            stateNext   = IDLE;
            tmoCntNext  = 8'd0;
            lockErrNext = 1'b1;
          end else begin
            tmoCntNext = tmoCnt + 8'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      prefer   <= 1'b0;
      tmoCnt   <= 8'd0;
      lock_err <= 1'b0;
    end else begin
      state    <= stateNext;
      tmoCnt   <= tmoCntNext;
      lock_err <= lockErrNext;
      if (accept) begin
        prefer <= ~grantId;
      end
    end
  end

  // Address and write data hold their last values when no beat is issued.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bram_en   <= 1'b0;
      bram_wen  <= '0;
      bram_addr <= '0;
      bram_dout <= '0;
    end else begin
      bram_en  <= accept;
      bram_wen <= (accept && grantWrite) ? grantBe : '0;
      if (accept) begin
        bram_addr <= grantAddr;
        bram_dout <= grantWdata;
      end
    end
  end

  assign tagIn = '{valid: accept && !grantWrite, id: grantId};

  md6_rd_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) tagPipe (
    .CLK    (CLK),
    .clear  (RST),
    .tagIn  (tagIn),
    .tagOut (tagOut)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= tagOut.valid && (tagOut.id == 1'b0);
      rsp1_valid <= tagOut.valid && (tagOut.id == 1'b1);
      if (tagOut.valid && tagOut.id == 1'b0) begin
        rsp0_data <= bram_din;
      end
      if (tagOut.valid && tagOut.id == 1'b1) begin
        rsp1_data <= bram_din;
      end
    end
  end

endmodule

// File: tb/tb_md6_bram_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared against
// a transaction-level model of grants, lock ownership, BRAM drive and responses.
module tb_md6_bram_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 1;
  localparam int LOCK_TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0_valid, req0_ready, req0_write, req0_lock;
  logic [13:0] req0_addr;
  logic [31:0] req0_wdata;
  logic [3:0]  req0_be;
  logic        req1_valid, req1_ready, req1_write, req1_lock;
  logic [13:0] req1_addr;
  logic [31:0] req1_wdata;
  logic [3:0]  req1_be;
  logic        rsp0_valid, rsp1_valid, lock_err, bram_en;
  logic [31:0] rsp0_data, rsp1_data, bram_dout, bram_din;
  logic [3:0]  bram_wen;
  logic [13:0] bram_addr;

  md6_bram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .LOCK_TMO(LOCK_TMO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_be(req0_be),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_be(req1_be),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .lock_err(lock_err),
    .bram_en(bram_en), .bram_wen(bram_wen), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .bram_din(bram_din)
  );

  always #5 CLK = ~CLK;

  // BRAM device with one cycle read latency.
  logic [31:0] bramMem [0:16383];
  logic [31:0] bramDinReg;
  assign bram_din = bramDinReg;

  always @(posedge CLK) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_wen[b]) bramMem[bram_addr][b*8 +: 8] <= bram_dout[b*8 +: 8];
      bramDinReg <= bramMem[bram_addr];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] refMem [0:16383];
  rsp_t        rspQ[$];
  int          owner, prefer, idleCnt, lastGrant;
  logic        expEn, expLockErr;
  logic [3:0]  expWen;
  logic [13:0] expAddr;
  logic [31:0] expDout, lastData0, lastData1;
  int          assertCount = 0;
  int          failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    owner = -1; prefer = 0; idleCnt = 0;
    rspQ.delete();
    expEn = 1'b0; expWen = 4'h0; expAddr = '0; expDout = '0; expLockErr = 1'b0;
    lastData0 = '0; lastData1 = '0;
  endtask

  task automatic doReset();
    RST = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    modelReset();
    checkOutput("rst_bram_en", 32'(bram_en), 32'(0));
    checkOutput("rst_bram_wen", 32'(bram_wen), 32'(0));
    checkOutput("rst_bram_addr", 32'(bram_addr), 32'(0));
    checkOutput("rst_bram_dout", bram_dout, 32'(0));
    checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'(0));
    checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'(0));
    checkOutput("rst_rsp0_data", rsp0_data, 32'(0));
    checkOutput("rst_rsp1_data", rsp1_data, 32'(0));
    checkOutput("rst_lock_err", 32'(lock_err), 32'(0));
    checkOutput("rst_ready0", 32'(req0_ready), 32'(0));
    checkOutput("rst_ready1", 32'(req1_ready), 32'(0));
    RST = 1'b0;
  endtask

  // One cycle: drive at the falling edge, check, advance the model.
  task automatic applyStimulus(
    input logic v0, input logic w0, input logic l0, input logic [13:0] a0,
    input logic [31:0] d0, input logic [3:0] b0,
    input logic v1, input logic w1, input logic l1, input logic [13:0] a1,
    input logic [31:0] d1, input logic [3:0] b1);
    int g;
    logic e0, e1, w, l, nextLockErr;
    logic [31:0] ed, d;
    logic [13:0] a;
    logic [3:0] b;
    req0_valid = v0; req0_write = w0; req0_lock = l0; req0_addr = a0; req0_wdata = d0; req0_be = b0;
    req1_valid = v1; req1_write = w1; req1_lock = l1; req1_addr = a1; req1_wdata = d1; req1_be = b1;
    #1;
    checkOutput("bram_en", 32'(bram_en), 32'(expEn));
    checkOutput("bram_wen", 32'(bram_wen), 32'(expWen));
    checkOutput("bram_addr", 32'(bram_addr), 32'(expAddr));
    checkOutput("bram_dout", bram_dout, expDout);
    checkOutput("lock_err", 32'(lock_err), 32'(expLockErr));
    e0 = 1'b0; e1 = 1'b0; ed = '0;
    if (rspQ.size() > 0 && rspQ[0].due == cyc) begin
      if (rspQ[0].id == 0) e0 = 1'b1; else e1 = 1'b1;
      ed = rspQ[0].data;
      void'(rspQ.pop_front());
    end
    if (e0) lastData0 = ed;
    if (e1) lastData1 = ed;
    checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(e0));
    checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(e1));
    checkOutput("rsp0_data", rsp0_data, lastData0);
    checkOutput("rsp1_data", rsp1_data, lastData1);

    if (owner == 0)      g = v0 ? 0 : -1;
    else if (owner == 1) g = v1 ? 1 : -1;
    else if (v0 && v1)   g = prefer;
    else if (v0)         g = 0;
    else if (v1)         g = 1;
    else                 g = -1;
    lastGrant = g;
    checkOutput("req0_ready", 32'(req0_ready), 32'(g == 0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(g == 1));

    nextLockErr = 1'b0;
    expEn = 1'b0;
    expWen = 4'h0;
    if (g >= 0) begin
      w = (g == 1) ? w1 : w0;  l = (g == 1) ? l1 : l0;
      a = (g == 1) ? a1 : a0;  d = (g == 1) ? d1 : d0;  b = (g == 1) ? b1 : b0;
      expEn = 1'b1; expWen = w ? b : 4'h0; expAddr = a; expDout = d;
      if (w) begin
        for (int k = 0; k < 4; k++) if (b[k]) refMem[a][k*8 +: 8] = d[k*8 +: 8];
      end else begin
        rspQ.push_back('{due: cyc + 2 + RD_LAT, id: g, data: refMem[a]});
      end
      prefer = 1 - g;
      idleCnt = 0;
      if (owner < 0) begin
        if (l) owner = g;
      end else if (!l) begin
        owner = -1;
      end
    end else if (owner >= 0) begin
      idleCnt++;
      if (idleCnt == LOCK_TMO) begin
        owner = -1; idleCnt = 0; nextLockErr = 1'b1;
      end
    end
    expLockErr = nextLockErr;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0);
  endtask

  logic        pv[2], pw[2], pl[2];
  logic [13:0] pa[2];
  logic [31:0] pd[2];
  logic [3:0]  pb[2];

  initial begin
    for (int i = 0; i < 16384; i++) begin
      bramMem[i] = 32'hC0DE0000 + 32'(i);
      refMem[i]  = 32'hC0DE0000 + 32'(i);
    end
    bramMem[16'h0010] = 32'hDEADBEEF;
    refMem[16'h0010]  = 32'hDEADBEEF;
    bramDinReg = '0;
    req0_write = 0; req0_lock = 0; req0_addr = '0; req0_wdata = '0; req0_be = '0;
    req1_write = 0; req1_lock = 0; req1_addr = '0; req1_wdata = '0; req1_be = '0;
    doReset();

    $display("[TB] single read and byte write");
    applyStimulus(1, 0, 0, 14'h0010, '0, '0, 0, 0, 0, '0, '0, '0);
    idleCycles(4);
    applyStimulus(0, 0, 0, '0, '0, '0, 1, 1, 0, 14'h3FFF, 32'h11223344, 4'b0101);
    idleCycles(1);
    applyStimulus(1, 0, 0, 14'h3FFF, '0, '0, 0, 0, 0, '0, '0, '0);
    idleCycles(3);

    $display("[TB] round robin");
    doReset();
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 0, 0, 14'h0020, '0, '0, 1, 0, 0, 14'h0021, '0, '0);
    idleCycles(3);

    $display("[TB] locked burst");
    applyStimulus(1, 0, 0, 14'h0030, '0, '0, 0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, 14'h0031, '0, '0, 1, 0, 1, 14'h0040, '0, '0);
    applyStimulus(1, 0, 0, 14'h0031, '0, '0, 1, 1, 1, 14'h0041, 32'hA1B2C3D4, 4'hF);
    applyStimulus(1, 0, 0, 14'h0031, '0, '0, 1, 0, 1, 14'h0041, '0, '0);
    applyStimulus(1, 0, 0, 14'h0031, '0, '0, 1, 0, 0, 14'h0042, '0, '0);
    applyStimulus(1, 0, 0, 14'h0031, '0, '0, 0, 0, 0, '0, '0, '0);
    idleCycles(3);

    $display("[TB] lock timeout");
    applyStimulus(1, 0, 1, 14'h0050, '0, '0, 0, 0, 0, '0, '0, '0);
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 0, 0, '0, '0, '0, 1, 0, 0, 14'h0051, '0, '0);
    idleCycles(3);

    $display("[TB] reset during read");
    applyStimulus(1, 0, 0, 14'h0010, '0, '0, 0, 0, 0, '0, '0, '0);
    doReset();
    idleCycles(5);

    $display("[TB] random traffic");
    for (int r = 0; r < 2; r++) pv[r] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 1) == 1) begin
          pv[r] = 1'b1;
          pw[r] = ($urandom_range(0, 2) == 0);
          pl[r] = ($urandom_range(0, 5) == 0);
          pa[r] = 14'($urandom_range(0, 31));
          pd[r] = $urandom();
          pb[r] = 4'($urandom_range(1, 15));
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        doReset();
      end else begin
        applyStimulus(pv[0], pw[0], pl[0], pa[0], pd[0], pb[0],
                      pv[1], pw[1], pl[1], pa[1], pd[1], pb[1]);
        if (lastGrant >= 0) pv[lastGrant] = 1'b0;
      end
    end
    idleCycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
